// File: rtl/wb_seg7_scanner.sv
// Four-digit multiplexed 7-segment scanner: one Wishbone byte write per digit to the
// shift-register driver, then lights that digit's anode for HOLD_CYCLES clocks.
module wb_seg7_scanner #(
   parameter int unsigned HOLD_CYCLES = 25000,
   parameter int unsigned HOLD_WIDTH  = 15
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_enable,
   input  logic [15:0] i_value,
   input  logic [3:0]  i_dp,
   input  logic [3:0]  i_blank,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic [7:0]  o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   output logic [3:0]  o_digit_n,
   output logic        o_frame_stb
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_SHOW      = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [1:0]            index_q, index_d;
   logic [HOLD_WIDTH-1:0] hold_q, hold_d;
   logic                  first_q, first_d;
   logic [15:0]           value_q, value_d;
   logic [3:0]            dp_q, dp_d;
   logic [3:0]            blank_q, blank_d;
   logic                  cyc_q, cyc_d;
   logic                  stb_q, stb_d;
   logic [7:0]            data_q, data_d;
   logic [3:0]            digit_n_q, digit_n_d;
   logic                  frame_stb_q, frame_stb_d;

   logic [15:0]           val_sel;
   logic [3:0]            dp_sel;
   logic [3:0]            blank_sel;
   logic [3:0]            nibble;
   logic [7:0]            seg;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'h3F;
         4'h1: hex_font = 7'h06;
         4'h2: hex_font = 7'h5B;
         4'h3: hex_font = 7'h4F;
         4'h4: hex_font = 7'h66;
         4'h5: hex_font = 7'h6D;
         4'h6: hex_font = 7'h7D;
         4'h7: hex_font = 7'h07;
         4'h8: hex_font = 7'h7F;
         4'h9: hex_font = 7'h6F;
         4'hA: hex_font = 7'h77;
         4'hB: hex_font = 7'h7C;
         4'hC: hex_font = 7'h39;
         4'hD: hex_font = 7'h5E;
         4'hE: hex_font = 7'h79;
         default: hex_font = 7'h71;
      endcase
   endfunction

   // Digit 0 reads the live inputs in the same cycle they are captured into the shadow.
   always_comb begin
      val_sel   = (index_q == 2'd0) ? i_value : value_q;
      dp_sel    = (index_q == 2'd0) ? i_dp    : dp_q;
      blank_sel = (index_q == 2'd0) ? i_blank : blank_q;
      nibble    = val_sel[{index_q, 2'b00} +: 4];
      if (blank_sel[index_q])
         seg = '0;
      else
         seg = {dp_sel[index_q], hex_font(nibble)};
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      hold_d      = hold_q;
      first_d     = first_q;
      value_d     = value_q;
      dp_d        = dp_q;
      blank_d     = blank_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      data_d      = data_q;
      digit_n_d   = digit_n_q;
      frame_stb_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            digit_n_d = '1;
            if (i_enable)
               state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (index_q == 2'd0) begin
               value_d = i_value;
               dp_d    = i_dp;
               blank_d = i_blank;
            end
            data_d  = seg;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (i_wb_ack) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               first_d = 1'b1;
               state_d = ST_WAIT_DONE;
            end else if (!i_wb_stall) begin
               stb_d   = 1'b0;
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (i_wb_ack) begin
               cyc_d   = 1'b0;
               first_d = 1'b1;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // Driver raises stall together with ack, so the first cycle here is not trusted.
            first_d = 1'b0;
            if (!first_q && !i_wb_stall) begin
               hold_d    = HOLD_WIDTH'(HOLD_CYCLES - 1);
               digit_n_d = ~(4'b0001 << index_q);
               state_d   = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (hold_q == '0) begin
               digit_n_d   = '1;
               index_d     = index_q + 2'd1;
               frame_stb_d = (index_q == 2'd3);
               state_d     = i_enable ? ST_LOAD : ST_IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            digit_n_d = '1;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         hold_q      <= '0;
         first_q     <= 1'b0;
         value_q     <= '0;
         dp_q        <= '0;
         blank_q     <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         data_q      <= '0;
         digit_n_q   <= '1;
         frame_stb_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         hold_q      <= hold_d;
         first_q     <= first_d;
         value_q     <= value_d;
         dp_q        <= dp_d;
         blank_q     <= blank_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         data_q      <= data_d;
         digit_n_q   <= digit_n_d;
         frame_stb_q <= frame_stb_d;
      end
   end

   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_data   = data_q;
   assign o_digit_n   = digit_n_q;
   assign o_frame_stb = frame_stb_q;

endmodule
